// File: rtl/fram_spi_controller.sv
// fram_spi_controller: word-oriented SPI mode-0 master for an MB85RS-style FRAM.
// Serves one 16-bit read or write per accepted start. A write issues WREN first.
// Each word is stored big-endian at byte address {addr[14:0], 1'b0}.
module fram_spi_controller #(
  parameter int unsigned DIV    = 2,  // SCK half-period in clk cycles
  parameter int unsigned CS_GAP = 4   // cs-high cycles after every frame
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] addr,
  input  logic [15:0] data_in,
  input  logic        we,
  input  logic        start,
  output logic [15:0] data_out,
  output logic        done,
  output logic        busy,
  output logic        spi_sck,
  output logic        spi_mosi,
  input  logic        spi_miso,
  output logic        spi_cs
);

  localparam int unsigned DivW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int unsigned GapW = (CS_GAP > 1) ? $clog2(CS_GAP) : 1;

  localparam logic [2:0] StIdle       = 3'd0;
  localparam logic [2:0] StWrenShift  = 3'd1;
  localparam logic [2:0] StWrenGap    = 3'd2;
  localparam logic [2:0] StFrameShift = 3'd3;
  localparam logic [2:0] StFinish     = 3'd4;

  localparam logic [7:0] CmdWren  = 8'h06;
  localparam logic [7:0] CmdWrite = 8'h02;
  localparam logic [7:0] CmdRead  = 8'h03;

  logic [2:0]      state_q, state_d;
  logic [DivW-1:0] div_q, div_d;
  logic [5:0]      bit_q, bit_d;
  logic [GapW-1:0] gap_q, gap_d;
  logic [39:0]     tx_q, tx_d;
  logic [15:0]     rx_q, rx_d;
  logic            sck_q, sck_d;
  logic            cs_q, cs_d;
  logic            done_q, done_d;
  logic            busy_q, busy_d;
  logic            we_q, we_d;
  logic [14:0]     addr_q, addr_d;
  logic [15:0]     wdata_q, wdata_d;
  logic [15:0]     data_out_q, data_out_d;
  logic [5:0]      last_bit;

  // Bit 15 of the word address has no meaning for the FRAM.
  logic unused_addr_msb;
  assign unused_addr_msb = addr[15];

  assign last_bit = (state_q == StWrenShift) ? 6'd7 : 6'd39;

  // Next-state logic: request accept, bit shifting, cs gaps and completion.
  always_comb begin
    state_d    = state_q;
    div_d      = div_q;
    bit_d      = bit_q;
    gap_d      = gap_q;
    tx_d       = tx_q;
    rx_d       = rx_q;
    sck_d      = sck_q;
    cs_d       = cs_q;
    done_d     = 1'b0;
    busy_d     = busy_q;
    we_d       = we_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    data_out_d = data_out_q;

    case (state_q)
      StIdle: begin
        // busy stays high through the done cycle, drops on the next edge
        busy_d = 1'b0;
        if (start) begin
          addr_d  = addr[14:0];
          wdata_d = data_in;
          we_d    = we;
          busy_d  = 1'b1;
          cs_d    = 1'b0;
          sck_d   = 1'b0;
          div_d   = '0;
          bit_d   = '0;
          if (we) begin
            tx_d    = {CmdWren, 32'h0};
            state_d = StWrenShift;
          end else begin
            tx_d    = {CmdRead, addr[14:0], 1'b0, 16'h0};
            state_d = StFrameShift;
          end
        end
      end

      StWrenShift, StFrameShift: begin
        if (div_q == DivW'(DIV - 1)) begin
          div_d = '0;
          if (!sck_q) begin
            sck_d = 1'b1;
            // Shift on every rising edge; the last 16 are the read word.
            rx_d  = {rx_q[14:0], spi_miso};
          end else begin
            sck_d = 1'b0;
            if (bit_q == last_bit) begin
              cs_d    = 1'b1;
              tx_d    = '0;
              gap_d   = '0;
              state_d = (state_q == StWrenShift) ? StWrenGap : StFinish;
            end else begin
              bit_d = bit_q + 6'd1;
              tx_d  = {tx_q[38:0], 1'b0};
            end
          end
        end else begin
          div_d = div_q + 1'b1;
        end
      end

      StWrenGap: begin
        if (gap_q == GapW'(CS_GAP - 1)) begin
          cs_d    = 1'b0;
          div_d   = '0;
          bit_d   = '0;
          tx_d    = {CmdWrite, addr_q, 1'b0, wdata_q};
          state_d = StFrameShift;
        end else begin
          gap_d = gap_q + 1'b1;
        end
      end

      StFinish: begin
        if (gap_q == GapW'(CS_GAP - 1)) begin
          done_d  = 1'b1;
          state_d = StIdle;
          if (!we_q) begin
            data_out_d = rx_q;
          end
        end else begin
          gap_d = gap_q + 1'b1;
        end
      end

      default: begin
        state_d = StIdle;
        cs_d    = 1'b1;
        sck_d   = 1'b0;
        tx_d    = '0;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State registers; reset abandons any transaction in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      div_q      <= '0;
      bit_q      <= '0;
      gap_q      <= '0;
      tx_q       <= '0;
      rx_q       <= '0;
      sck_q      <= 1'b0;
      cs_q       <= 1'b1;
      done_q     <= 1'b0;
      busy_q     <= 1'b0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      data_out_q <= '0;
    end else begin
      state_q    <= state_d;
      div_q      <= div_d;
      bit_q      <= bit_d;
      gap_q      <= gap_d;
      tx_q       <= tx_d;
      rx_q       <= rx_d;
      sck_q      <= sck_d;
      cs_q       <= cs_d;
      done_q     <= done_d;
      busy_q     <= busy_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      data_out_q <= data_out_d;
    end
  end

  assign spi_sck  = sck_q;
  assign spi_cs   = cs_q;
  assign spi_mosi = tx_q[39];
  assign done     = done_q;
  assign busy     = busy_q;
  assign data_out = data_out_q;

endmodule

// File: tb/tb_fram_spi_controller.sv
// Self-checking bench for fram_spi_controller with a behavioural SPI FRAM model.
module tb_fram_spi_controller;

  localparam int unsigned DIV    = 2;
  localparam int unsigned CS_GAP = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] addr;
  logic [15:0] data_in;
  logic        we;
  logic        start;
  logic [15:0] data_out;
  logic        done;
  logic        busy;
  logic        spi_sck;
  logic        spi_mosi;
  logic        spi_miso;
  logic        spi_cs;

  fram_spi_controller #(.DIV(DIV), .CS_GAP(CS_GAP)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .addr     (addr),
    .data_in  (data_in),
    .we       (we),
    .start    (start),
    .data_out (data_out),
    .done     (done),
    .busy     (busy),
    .spi_sck  (spi_sck),
    .spi_mosi (spi_mosi),
    .spi_miso (spi_miso),
    .spi_cs   (spi_cs)
  );

  always #5 clk = ~clk;

  int n_total = 0;
  int n_bad   = 0;

  task automatic check(input string tag, input logic [39:0] got, input logic [39:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Scoreboards: expected MOSI bytes and expected data_out at each done.
  logic [7:0]  exp_bytes[$];
  logic [15:0] exp_data[$];
  logic [15:0] last_rd = 16'h0000;

  // FRAM model
  logic [7:0]  mem [0:65535];
  logic [39:0] sr;
  int          bcnt = 0;
  logic        rd_active = 1'b0;
  logic [15:0] rd_word;
  logic [15:0] ma;
  logic [7:0]  eb;

  always @(spi_sck or posedge spi_cs) begin
    if (spi_cs === 1'b1) begin
      bcnt      = 0;
      spi_miso  = 1'b0;
      rd_active = 1'b0;
    end else if (spi_sck === 1'b1) begin
      sr = {sr[38:0], spi_mosi};
      bcnt++;
      if (bcnt % 8 == 0) begin
        if (exp_bytes.size() == 0) check("mosi_extra_byte", exp_bytes.size(), 1);
        else begin
          eb = exp_bytes.pop_front();
          check("mosi_byte", sr[7:0], eb);
        end
      end
      if (bcnt == 24 && sr[23:16] == 8'h03) begin
        ma        = sr[15:0];
        rd_word   = {mem[ma], mem[ma + 16'd1]};
        rd_active = 1'b1;
      end
      if (bcnt == 40 && sr[39:32] == 8'h02) begin
        ma          = sr[31:16];
        mem[ma]     = sr[15:8];
        mem[ma + 16'd1] = sr[7:0];
      end
    end else if (spi_sck === 1'b0) begin
      if (rd_active && bcnt >= 24 && bcnt < 40) spi_miso = rd_word[39 - bcnt];
    end
  end

  // Frame counter and cs-high gap measurement (sampled mid-cycle).
  int frames  = 0;
  int hi_run  = 0;
  int last_gap = 0;
  always @(negedge spi_cs) frames++;
  always @(negedge clk) begin
    if (spi_cs) hi_run++;
    else if (hi_run > 0) begin
      last_gap = hi_run;
      hi_run   = 0;
    end
  end

  task automatic push_bytes(input logic w, input logic [15:0] a, input logic [15:0] d);
    logic [15:0] ba;
    ba = {a[14:0], 1'b0};
    if (w) begin
      exp_bytes.push_back(8'h06);
      exp_bytes.push_back(8'h02);
      exp_bytes.push_back(ba[15:8]);
      exp_bytes.push_back(ba[7:0]);
      exp_bytes.push_back(d[15:8]);
      exp_bytes.push_back(d[7:0]);
    end else begin
      exp_bytes.push_back(8'h03);
      exp_bytes.push_back(ba[15:8]);
      exp_bytes.push_back(ba[7:0]);
      exp_bytes.push_back(8'h00);
      exp_bytes.push_back(8'h00);
    end
  endtask

  // One transaction; hold = edges start stays high (including the accept edge).
  task automatic run_txn(input string tag, input logic w, input logic [15:0] a,
                         input logic [15:0] d, input logic [15:0] rd_exp, input int hold,
                         input int exp_lat, input int exp_frames);
    int cyc;
    int f0;
    int busy_low;
    logic seen;
    logic [15:0] got;
    push_bytes(w, a, d);
    exp_data.push_back(w ? last_rd : rd_exp);
    if (!w) last_rd = rd_exp;
    @(negedge clk);
    we = w; addr = a; data_in = d; start = 1'b1;
    f0 = frames;
    @(posedge clk); #1;
    check({tag, "_accept_busy"}, busy, 1);
    check({tag, "_accept_cs"}, spi_cs, 0);
    cyc = 0; seen = 1'b0; busy_low = 0;
    while (!seen && cyc < 2000) begin
      if (cyc + 1 == hold) begin
        start = 1'b0; addr = ~a; data_in = ~d;
      end
      @(posedge clk); #1;
      cyc++;
      if (done) seen = 1'b1;
      if (!busy) busy_low++;
    end
    check({tag, "_latency"}, cyc, exp_lat);
    check({tag, "_busy_held"}, busy_low, 0);
    got = data_out;
    if (exp_data.size() == 0) check({tag, "_data_unexpected"}, exp_data.size(), 1);
    else check({tag, "_data_out"}, got, exp_data.pop_front());
    check({tag, "_frames"}, frames - f0, exp_frames);
    @(posedge clk); #1;
    check({tag, "_done_single"}, done, 0);
    check({tag, "_busy_after"}, busy, 0);
    repeat (6) @(posedge clk);
    #1 check({tag, "_no_requeue"}, busy, 0);
  endtask

  initial begin
    int dn;
    for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
    mem[16'h000A] = 8'hBE; mem[16'h000B] = 8'hEF;
    mem[16'h0006] = 8'hFF; mem[16'h0007] = 8'hFF;
    mem[16'h0020] = 8'h13; mem[16'h0021] = 8'h57;
    rst_n = 1'b0; addr = '0; data_in = '0; we = 1'b0; start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_cs", spi_cs, 1);
    check("rst_sck", spi_sck, 0);
    check("rst_mosi", spi_mosi, 0);
    check("rst_done", done, 0);
    check("rst_busy", busy, 0);
    check("rst_data_out", data_out, 16'h0000);
    @(negedge clk) rst_n = 1'b1;
    repeat (3) @(posedge clk);

    run_txn("rd5", 1'b0, 16'h0005, 16'h0000, 16'hBEEF, 1, 164, 1);

    run_txn("wr", 1'b1, 16'h1234, 16'h8001, 16'h0000, 1, 200, 2);
    check("wr_wren_gap", last_gap, CS_GAP);
    check("wr_mem_hi", mem[16'h2468], 8'h80);
    check("wr_mem_lo", mem[16'h2469], 8'h01);

    run_txn("hold", 1'b0, 16'h0010, 16'h0000, 16'h1357, 2, 164, 1);

    run_txn("rd8003", 1'b0, 16'h8003, 16'h0000, 16'hFFFF, 1, 164, 1);

    // Idle reset clears data_out.
    @(negedge clk) rst_n = 1'b0;
    #1;
    check("idle_rst_data_out", data_out, 16'h0000);
    check("idle_rst_cs", spi_cs, 1);
    check("idle_rst_busy", busy, 0);
    last_rd = 16'h0000;
    @(negedge clk) rst_n = 1'b1;
    repeat (2) @(posedge clk);

    // Reset 50 cycles into a write.
    push_bytes(1'b1, 16'h1234, 16'h5555);
    @(negedge clk);
    we = 1'b1; addr = 16'h1234; data_in = 16'h5555; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    repeat (49) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("abort_cs", spi_cs, 1);
    check("abort_sck", spi_sck, 0);
    check("abort_busy", busy, 0);
    dn = 0;
    repeat (5) begin
      @(posedge clk); #1;
      if (done) dn++;
    end
    check("abort_no_done", dn, 0);
    exp_bytes.delete();
    exp_data.delete();
    last_rd = 16'h0000;
    @(negedge clk) rst_n = 1'b1;
    repeat (2) @(posedge clk);
    check("abort_mem_untouched", mem[16'h2469], 8'h01);

    run_txn("post_abort", 1'b0, 16'h0005, 16'h0000, 16'hBEEF, 1, 164, 1);

    check("mosi_left", exp_bytes.size(), 0);
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
